audio_comp_scheduler: RTL

- Frame sequencer for the shared audio compressor datapath.
- On each sample-rate strobe it does four things in order:
  - reads NUM_SRC stereo sources through a valid/ready handshake;
  - applies a per-source gain and mixes the sources into one wide accumulator pair;
  - presents the mix to the compressor with a single-cycle enable, or with the enable held low in bypass;
  - captures the compressor's result after a fixed latency.
- Sits between the sound sources (speaker, Mockingboard voices, etc.) and the codec/HDMI audio output.

---
 rtl/audio_comp_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/audio_comp_scheduler.sv
// audio_comp_scheduler: per-strobe mix of NUM_SRC gained stereo sources, compressor issue and result capture
module audio_comp_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int SRC_WIDTH    = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int OUT_WIDTH    = 16,
  parameter int COMP_LATENCY = 3
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            sample_strobe_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  input  logic [NUM_SRC*SRC_WIDTH-1:0]    src_l_i,
  input  logic [NUM_SRC*SRC_WIDTH-1:0]    src_r_i,
  input  logic [NUM_SRC*GAIN_WIDTH-1:0]   src_gain_i,
  input  logic                            comp_bypass_i,
  output logic                            comp_enable_o,
  output logic signed [ACC_WIDTH-1:0]     comp_in_l_o,
  output logic signed [ACC_WIDTH-1:0]     comp_in_r_o,
  input  logic [OUT_WIDTH-1:0]            comp_out_l_i,
  input  logic [OUT_WIDTH-1:0]            comp_out_r_i,
  output logic [OUT_WIDTH-1:0]            audio_l_o,
  output logic [OUT_WIDTH-1:0]            audio_r_o,
  output logic                            audio_valid_o,
  output logic                            busy_o,
  output logic                            overrun_o,
  input  logic                            overrun_clr_i
);
  localparam int IW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW  = (COMP_LATENCY > 2) ? $clog2(COMP_LATENCY - 1) : 1;
  localparam int PRW = SRC_WIDTH + GAIN_WIDTH + 1;
  localparam int PW  = ((ACC_WIDTH > PRW) ? ACC_WIDTH : PRW) + 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_SRC - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((COMP_LATENCY > 1) ? COMP_LATENCY - 2 : 0);
  typedef enum logic [2:0] {IDLE, SUM, ISSUE, WAIT, CAPTURE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_wait;
  logic signed [SRC_WIDTH-1:0] r_hold_l [NUM_SRC];
  logic signed [SRC_WIDTH-1:0] r_hold_r [NUM_SRC];
  logic [GAIN_WIDTH-1:0] w_gain [NUM_SRC];
  logic [NUM_SRC-1:0] r_fresh, w_read, w_load;
  logic signed [ACC_WIDTH-1:0] r_acc_l, r_acc_r, w_mix_l, w_mix_r;
  logic r_vpend;
  function automatic logic signed [ACC_WIDTH-1:0] mix(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic signed [SRC_WIDTH-1:0] s,
    input logic [GAIN_WIDTH-1:0]       g
  );
    logic signed [PRW-1:0] p;
    logic signed [PW-1:0]  sum;
    p   = (PRW'(s) * PRW'($signed({1'b0, g}))) >>> 7;
    sum = PW'(acc) + PW'(p);
    mix = (&sum[PW-1:ACC_WIDTH-1] || !(|sum[PW-1:ACC_WIDTH-1])) ? sum[ACC_WIDTH-1:0]
        : {sum[PW-1], {(ACC_WIDTH-1){~sum[PW-1]}}};
  endfunction
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_gain[g] = src_gain_i[g*GAIN_WIDTH +: GAIN_WIDTH];
    assign w_read[g] = (r_state == SUM) && (r_idx == IW'(g));
    assign w_load[g] = src_valid_i[g] && src_ready_o[g];
  end
  assign src_ready_o = reset_n_i ? ~r_fresh : '0;
  assign busy_o      = r_state != IDLE;
  assign w_mix_l     = mix(r_acc_l, r_hold_l[r_idx], w_gain[r_idx]);
  assign w_mix_r     = mix(r_acc_r, r_hold_r[r_idx], w_gain[r_idx]);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = sample_strobe_i ? SUM : IDLE;
      SUM:     w_next = (r_idx == IDX_LAST) ? ISSUE : SUM;
      ISSUE:   w_next = (COMP_LATENCY > 1) ? WAIT : CAPTURE;
      WAIT:    w_next = (r_wait == WAIT_LAST) ? CAPTURE : WAIT;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // A load and a SUM read in the same cycle leave the slot fresh: the read saw the old value.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_fresh <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_hold_l[i] <= '0;
        r_hold_r[i] <= '0;
      end
    end else begin
      r_fresh <= w_load | (r_fresh & ~w_read);
      for (int i = 0; i < NUM_SRC; i++)
        if (w_load[i]) begin
          r_hold_l[i] <= src_l_i[i*SRC_WIDTH +: SRC_WIDTH];
          r_hold_r[i] <= src_r_i[i*SRC_WIDTH +: SRC_WIDTH];
        end
    end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_idx         <= '0;
      r_wait        <= '0;
      r_acc_l       <= '0;
      r_acc_r       <= '0;
      comp_in_l_o   <= '0;
      comp_in_r_o   <= '0;
      comp_enable_o <= 1'b0;
      audio_l_o     <= '0;
      audio_r_o     <= '0;
      r_vpend       <= 1'b0;
      audio_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      r_idx   <= (r_state == SUM) ? r_idx + IW'(1) : '0;
      r_wait  <= (r_state == WAIT) ? r_wait + CW'(1) : '0;
      r_acc_l <= (r_state == IDLE) ? '0 : (r_state == SUM) ? w_mix_l : r_acc_l;
      r_acc_r <= (r_state == IDLE) ? '0 : (r_state == SUM) ? w_mix_r : r_acc_r;
      if (r_state == ISSUE) begin
        comp_in_l_o <= r_acc_l;
        comp_in_r_o <= r_acc_r;
      end
      comp_enable_o <= (r_state == ISSUE) && !comp_bypass_i;
      if (r_state == CAPTURE) begin
        audio_l_o <= comp_out_l_i;
        audio_r_o <= comp_out_r_i;
      end
      r_vpend       <= r_state == CAPTURE;
      audio_valid_o <= r_vpend;
      overrun_o     <= (sample_strobe_i && r_state != IDLE) || (overrun_o && !overrun_clr_i);
    end
endmodule
